quad_byte_collector: RTL and testbench

//   Upstream feeder for the four-lane register/sum/AND stage.

---
 rtl/quad_byte_collector.sv | 133 +++++++++++++
 tb/tb_quad_byte_collector.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/quad_byte_collector.sv
// quad_byte_collector
//   Packs four consecutive words accepted over a valid/ready stream into one
//   parallel group (out1 = first word ... out4 = fourth word). The group is
//   held with out_valid until the consumer takes it with out_ready.
//
// Ports
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   abort                  synchronous clear of the partial or held group
//   in_data/in_valid       serial word stream
//   in_ready               combinational; collector accepts in_data this cycle
//   out1..out4, out_valid  held group and its valid flag
//   out_ready              consumer takes the group this cycle
//   fill                   words held: 0..3 while collecting, 4 while holding
//   group_count            delivered groups, wraps 255 -> 0
module quad_byte_collector #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             abort,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       fill,
    output logic [7:0]       group_count
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [WIDTH-1:0] out1_q, out1_d;
    logic [WIDTH-1:0] out2_q, out2_d;
    logic [WIDTH-1:0] out3_q, out3_d;
    logic [WIDTH-1:0] out4_q, out4_d;
    logic [7:0]       group_count_q, group_count_d;

    logic accept;
    logic take;

    // While holding, a new word is only accepted when the held group leaves
    // in the same cycle, which gives zero-bubble back-to-back groups.
    assign in_ready  = !abort && ((state_q == COLLECT) || out_ready);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready && !abort;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        out1_d        = out1_q;
        out2_d        = out2_q;
        out3_d        = out3_q;
        out4_d        = out4_q;
        group_count_d = group_count_q;

        if (abort) begin
            state_d = COLLECT;
            idx_d   = '0;
            out1_d  = '0;
            out2_d  = '0;
            out3_d  = '0;
            out4_d  = '0;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (accept) begin
                        unique case (idx_q)
                            2'd0: begin out1_d = in_data; idx_d = 2'd1; end
                            2'd1: begin out2_d = in_data; idx_d = 2'd2; end
                            2'd2: begin out3_d = in_data; idx_d = 2'd3; end
                            2'd3: begin
                                out4_d  = in_data;
                                idx_d   = '0;
                                state_d = HOLD;
                            end
                        endcase
                    end
                end
                HOLD: begin
                    if (take) begin
                        group_count_d = group_count_q + 8'd1;
                        state_d       = COLLECT;
                        if (accept) begin
                            out1_d = in_data;
                            idx_d  = 2'd1;
                        end else begin
                            idx_d  = '0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= COLLECT;
            idx_q         <= '0;
            out1_q        <= '0;
            out2_q        <= '0;
            out3_q        <= '0;
            out4_q        <= '0;
            group_count_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            out1_q        <= out1_d;
            out2_q        <= out2_d;
            out3_q        <= out3_d;
            out4_q        <= out4_d;
            group_count_q <= group_count_d;
        end
    end

    assign out1        = out1_q;
    assign out2        = out2_q;
    assign out3        = out3_q;
    assign out4        = out4_q;
    // idx is always 0 in HOLD, so this reads 4 while holding.
    assign fill        = {out_valid, idx_q};
    assign group_count = group_count_q;

endmodule

// File: tb/tb_quad_byte_collector.sv
module tb_quad_byte_collector;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       abort = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out1, out2, out3, out4;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] fill;
    logic [7:0] group_count;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned stalls = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  exp_gc = '0;

    quad_byte_collector #(.WIDTH(8)) dut (
        .clock(clock), .reset(reset), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out1(out1), .out2(out2), .out3(out3), .out4(out4),
        .out_valid(out_valid), .out_ready(out_ready),
        .fill(fill), .group_count(group_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: every take is compared against the oldest queued group.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready && !abort) begin
            if (exp_q.size() == 0) begin
                check("unexpected_group", {out1, out2, out3, out4}, 32'hxxxxxxxx);
            end else begin
                check("group_lanes", {out1, out2, out3, out4}, exp_q.pop_front());
                check("group_count_at_take", {24'd0, group_count}, {24'd0, exp_gc});
                exp_gc = exp_gc + 8'd1;
            end
        end
    end

    // Drive one word and wait (bounded) until it is accepted at a clock edge.
    task automatic push_word(input logic [7:0] d);
        int unsigned n = 0;
        logic ok;
        in_data  = d;
        in_valid = 1'b1;
        do begin
            @(negedge clock);
            ok = in_ready;
            @(posedge clock);
            #1;
            n++;
            if (!ok) stalls++;
        end while (!ok && n < 50);
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic push_group(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        exp_q.push_back({a, b, c, d});
        push_word(a);
        push_word(b);
        push_word(c);
        push_word(d);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned s0;

        // Test 1: reset state and a single group
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_fill", {29'd0, fill}, 32'd0);
        check("reset_group_count", {24'd0, group_count}, 32'd0);
        check("reset_lanes", {out1, out2, out3, out4}, 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        push_group(8'd10, 8'd20, 8'd12, 8'd5);
        check("t1_latency_valid", {31'd0, out_valid}, 32'd1);
        check("t1_fill_hold", {29'd0, fill}, 32'd4);
        tick();
        check("t1_valid_one_cycle", {31'd0, out_valid}, 32'd0);
        check("t1_group_count", {24'd0, group_count}, 32'd1);

        // Test 2: held group with backpressure
        out_ready = 1'b0;
        push_group(8'd55, 8'd55, 8'd55, 8'd55);
        in_valid = 1'b1;
        in_data  = 8'd99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("t2_in_ready_low", {31'd0, in_ready}, 32'd0);
            check("t2_fill4", {29'd0, fill}, 32'd4);
            check("t2_lanes_stable", {out1, out2, out3, out4},
                  {8'd55, 8'd55, 8'd55, 8'd55});
            @(posedge clock);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t2_group_count", {24'd0, group_count}, 32'd2);
        check("t2_released", {31'd0, out_valid}, 32'd0);

        // Test 3: back-to-back groups without bubbles
        s0 = stalls;
        push_group(8'd20, 8'd30, 8'd112, 8'd50);
        push_group(8'd20, 8'd21, 8'd90, 8'd54);
        check("t3_no_stall", stalls - s0, 32'd0);
        tick();
        check("t3_group_count", {24'd0, group_count}, 32'd4);

        // Test 4: abort a partial group
        push_word(8'd7);
        push_word(8'd9);
        check("t4_fill2", {29'd0, fill}, 32'd2);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd77;
        @(negedge clock);
        check("t4_abort_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clock);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        check("t4_fill0", {29'd0, fill}, 32'd0);
        check("t4_lanes_cleared", {16'd0, out1, out2}, 32'd0);
        push_group(8'd1, 8'd2, 8'd3, 8'd4);
        tick();
        check("t4_group_count", {24'd0, group_count}, 32'd5);

        // Test 5: asynchronous reset mid-group
        push_word(8'd3);
        push_word(8'd4);
        check("t5_fill2", {29'd0, fill}, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_fill", {29'd0, fill}, 32'd0);
        check("t5_async_lanes", {out1, out2, out3, out4}, 32'd0);
        check("t5_async_count", {24'd0, group_count}, 32'd0);
        check("t5_async_valid", {31'd0, out_valid}, 32'd0);
        exp_gc = '0;
        tick();
        reset = 1'b0;
        tick();

        // Test 6: 256 groups wrap the counter, then an aborted held group
        for (int g = 0; g < 256; g++) begin
            push_group(8'(g), 8'(g + 1), 8'(g + 2), 8'(g + 3));
        end
        tick();
        check("t6_wrap", {24'd0, group_count}, 32'd0);
        out_ready = 1'b0;
        push_word(8'd1);
        push_word(8'd1);
        push_word(8'd1);
        push_word(8'd1);
        check("t6_held", {31'd0, out_valid}, 32'd1);
        abort     = 1'b1;
        out_ready = 1'b1;
        tick();
        abort = 1'b0;
        check("t6_abort_valid", {31'd0, out_valid}, 32'd0);
        check("t6_abort_count", {24'd0, group_count}, 32'd0);
        check("t6_abort_lanes", {out1, out2, out3, out4}, 32'd0);
        tick();
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
